ind_to_bin: RTL
===============

# ind_to_bin

Receive-side decoder for the 4-digit multiplexed 7-segment indicator bus (S1..S4 digit selects, DA..DG segments). It samples the scanned bus, decodes each digit's segment pattern, assembles a complete frame into a 14-bit binary value 0..9999, and publishes a value only after two identical consecutive frames. It sits beside an indicator driver for loop-back self-test, or on a board that must read another unit's display.

## Interface
Parameters:
- SETTLE, 4: consecutive identical synchronized samples required before a digit is captured.
- TIMEOUT, 2**20: cycles without any capture before lock is dropped.
- SEL_ACT, 1: active level of S1..S4.
- SEG_ACT, 1: active (lit) level of DA..DG.

Ports:
- tg  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- S1..S4  in  1 each  digit selects; S1 = thousands, S4 = units. Asynchronous to tg.
- DA..DG  in  1 each  segments a..g: DA top, DB upper-right, DC lower-right, DD bottom, DE lower-left, DF upper-left, DG middle. Asynchronous to tg.
- value  out  14  last confirmed reading, binary.
- valid  out  1  one-cycle pulse when value is (re)written.
- err  out  1  one-cycle pulse when a completed frame contains an undecodable digit.
- lock  out  1  level; high while frames are being decoded successfully.

## Operation
- Input conditioning: all 11 inputs pass through 2-flop synchronizers, then are normalized by SEL_ACT/SEG_ACT to active-high.
- Scan window: the interval during which the same single select is active. Zero active selects or more than one active select (ghosting/blanking) means no window. A settle counter is cleared on any change of selects or segments and increments otherwise. When it reaches SETTLE-1 inside a window, the 7-bit pattern is captured into that digit's slot and its mask bit is set. There is at most one capture per window, and a new window requires a select change.
- Decode (bits g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, blank 0000000=0 (leading blank). Any other pattern sets the slot's bad flag.
- Slot rules: digits may arrive in any order. Re-capture of a slot before frame completion overwrites it (newest wins).
- Frame complete: the capture that makes the mask all-ones. On that edge, the four digits and bad flags are snapshotted and the mask is cleared, so capture of the next frame continues in parallel.
- Conversion FSM states:
  - IDLE → CONV on frame complete.
  - CONV runs 4 cycles, thousands to units: acc ← (acc<<3)+(acc<<1)+d. acc is 14 bits; the maximum 9999 never overflows.
  - CHECK then → IDLE.
- CHECK when any bad flag is set: pulse err, clear the previous-frame register and its have-prev flag, and leave value unchanged.
- CHECK when have-prev is set and acc equals prev: value ← acc, pulse valid, set lock, restart the timeout counter.
- CHECK in all remaining cases: prev ← acc, set have-prev.
- A frame completing while the FSM is not in IDLE is dropped. That cannot occur with SETTLE ≥ 2 and real scan rates.
- Timeout: the counter restarts on every capture. On reaching TIMEOUT-1: lock ← 0, mask cleared, have-prev cleared. value is held.

## Timing
- Reset values: value=0, valid=0, err=0, lock=0, mask=0, have-prev=0, FSM=IDLE, counters=0.
- Input-change latency to the capture edge: 2 (sync) + SETTLE cycles.
- Frame complete on capture edge E0, conversion on edges E1..E4, CHECK on edge E5. valid/err/value are registered on E5 and high for exactly the one cycle after E5.
- valid and err are never high in the same cycle.
- rst during CONV or CHECK: no valid/err pulse, snapshot discarded.
- Capture on the same edge as a timeout expiry: capture wins (counter restarts, mask gets the new bit, lock cleared).

## Test plan
- Scan "1234" (SETTLE+3 cycles/digit, S1→S4) for two frames → exactly one valid pulse, value=0x04D2, lock=1; a third identical frame → another valid, same value.
- Frames 0042, 0043, 0043 → a single valid with value=43 after the third frame; value stays 0 before it.
- Frame with S3 segments 1110001 → err pulse 5 cycles after its fourth capture, no valid. The next good frame alone gives no valid (history cleared).
- S1 and S2 active together for 20 cycles, then a normal scan → no capture during overlap; first valid only after two clean frames.
- Steady 9999 → value=0x270F. Blank-blank-blank-7 → value=7. Stop scanning for TIMEOUT cycles (use TIMEOUT=64) → lock falls, value held.
- Assert rst on E2 of a conversion → no valid/err, all outputs at reset values, decoding resumes on the following frames.

Source files
------------

// File: rtl/ind_to_bin_if.sv
// Scanned 7-segment indicator bus plus the decoded reading published back by the receiver.
// The indicator side is the master; the decoder is the slave.
interface ind_to_bin_if;
  logic        S1, S2, S3, S4;
  logic        DA, DB, DC, DD, DE, DF, DG;
  logic [13:0] value;
  logic        valid;
  logic        err;
  logic        lock;

  modport master (
    output S1, S2, S3, S4,
    output DA, DB, DC, DD, DE, DF, DG,
    input  value, valid, err, lock
  );

  modport slave (
    input  S1, S2, S3, S4,
    input  DA, DB, DC, DD, DE, DF, DG,
    output value, valid, err, lock
  );
endinterface

// File: rtl/ind_to_bin.sv
// Receive-side decoder for a 4-digit multiplexed 7-segment bus: samples the scan, decodes digits,
// converts complete frames to binary and publishes a reading after two identical frames.
module ind_to_bin #(
  parameter int   SETTLE  = 4,
  parameter int   TIMEOUT = 2**20,
  parameter logic SEL_ACT = 1'b1,
  parameter logic SEG_ACT = 1'b1
) (
  input  logic        tg,
  input  logic        rst,
  ind_to_bin_if.slave bus
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  logic [10:0]   raw;
  logic [10:0]   sync1;
  logic [10:0]   sync2;
  logic [3:0]    sel;
  logic [6:0]    seg;
  logic [3:0]    prev_sel;
  logic [6:0]    prev_seg;
  logic          sel_chg;
  logic          any_chg;
  logic          window;
  logic          captured;
  logic          captured_eff;
  logic          capture;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    slot;
  logic [4:0]    dec;

  logic [3:0]    digs [4];
  logic [3:0]    bads;
  logic [3:0]    next_digs [4];
  logic [3:0]    next_bads;
  logic [3:0]    mask;
  logic [3:0]    mask_base;
  logic [3:0]    mask_new;
  logic          frame_done;

  logic [TW-1:0] tcnt;
  logic          expire;

  logic [1:0]    state;
  logic [1:0]    step;
  logic [3:0]    snap_digs [4];
  logic [3:0]    snap_bads;
  logic [13:0]   acc;
  logic [13:0]   prev_val;
  logic          have_prev;
  logic          check_hit;

  logic [13:0]   value_q;
  logic          valid_q;
  logic          err_q;
  logic          lock_q;

  assign raw = {bus.S4, bus.S3, bus.S2, bus.S1,
                bus.DG, bus.DF, bus.DE, bus.DD, bus.DC, bus.DB, bus.DA};

  // Segment pattern (g..a) to {bad, digit}; an all-dark digit reads as a leading zero.
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b0111111: r = 5'h00;
      7'b0000110: r = 5'h01;
      7'b1011011: r = 5'h02;
      7'b1001111: r = 5'h03;
      7'b1100110: r = 5'h04;
      7'b1101101: r = 5'h05;
      7'b1111101: r = 5'h06;
      7'b0000111: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1101111: r = 5'h09;
      7'b0000000: r = 5'h00;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  always_ff @(posedge tg) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign sel     = sync2[10:7] ^ {4{~SEL_ACT}};
  assign seg     = sync2[6:0]  ^ {7{~SEG_ACT}};
  assign sel_chg = (sel != prev_sel);
  assign any_chg = sel_chg | (seg != prev_seg);
  assign window  = $onehot(sel);

  // Capture fires on the edge the settle count reaches its limit, once per select window.
  always_comb begin
    cnt_next = cnt;
    if (any_chg)
      cnt_next = '0;
    else if (cnt != CNT_MAX)
      cnt_next = cnt + 1'b1;
  end

  assign captured_eff = sel_chg ? 1'b0 : captured;
  assign capture      = window & ~captured_eff & (cnt_next == CNT_MAX);
  assign dec          = decode_seg(seg);
  assign expire       = (tcnt == TMO_MAX);

  always_comb begin
    slot = 2'd0;
    if (sel[1]) slot = 2'd1;
    if (sel[2]) slot = 2'd2;
    if (sel[3]) slot = 2'd3;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      next_digs[i] = digs[i];
      next_bads[i] = bads[i];
      if (capture && (slot == 2'(i))) begin
        next_digs[i] = dec[3:0];
        next_bads[i] = dec[4];
      end
    end
  end

  // An expiring timeout empties the mask before a simultaneous capture adds its bit.
  assign mask_base  = expire ? 4'b0000 : mask;
  assign mask_new   = mask_base | sel;
  assign frame_done = capture & (mask_new == 4'b1111);

  assign check_hit = (state == ST_CHECK) && (snap_bads == 4'b0000) &&
                     have_prev && (acc == prev_val);

  always_ff @(posedge tg) begin
    if (rst) begin
      prev_sel <= '0;
      prev_seg <= '0;
      cnt      <= '0;
      captured <= 1'b0;
      mask     <= '0;
      bads     <= '0;
      for (int i = 0; i < 4; i++)
        digs[i] <= '0;
    end else begin
      prev_sel <= sel;
      prev_seg <= seg;
      cnt      <= cnt_next;
      captured <= captured_eff | capture;
      if (capture) begin
        bads <= next_bads;
        for (int i = 0; i < 4; i++)
          digs[i] <= next_digs[i];
      end
      if (frame_done)
        mask <= 4'b0000;
      else if (capture)
        mask <= mask_new;
      else if (expire)
        mask <= 4'b0000;
    end
  end

  // Conversion, frame comparison, publication and loss-of-lock supervision.
  always_ff @(posedge tg) begin
    if (rst) begin
      state     <= ST_IDLE;
      step      <= '0;
      acc       <= '0;
      prev_val  <= '0;
      have_prev <= 1'b0;
      snap_bads <= '0;
      for (int i = 0; i < 4; i++)
        snap_digs[i] <= '0;
      tcnt      <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (capture || expire || check_hit)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (frame_done) begin
            snap_bads <= next_bads;
            for (int i = 0; i < 4; i++)
              snap_digs[i] <= next_digs[i];
            acc   <= '0;
            step  <= '0;
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          acc  <= (acc << 3) + (acc << 1) + {10'd0, snap_digs[step]};
          step <= step + 1'b1;
          if (step == 2'd3)
            state <= ST_CHECK;
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (snap_bads != 4'b0000) begin
            err_q     <= 1'b1;
            have_prev <= 1'b0;
            prev_val  <= '0;
          end else if (check_hit) begin
            value_q <= acc;
            valid_q <= 1'b1;
            lock_q  <= 1'b1;
          end else begin
            prev_val  <= acc;
            have_prev <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (expire) begin
        lock_q    <= 1'b0;
        have_prev <= 1'b0;
      end
    end
  end

  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.lock  = lock_q;

endmodule
